// File: rtl/uart_tx.sv
// uart_tx: 8N1 (or 8N2) UART transmitter.
// Serialises one byte per frame onto tx. The frame order is start bit, data bits LSB first,
// then the stop bit(s). A new byte is only accepted in IDLE, and only while the far end
// holds CTS asserted (active low).
module uart_tx #(
    parameter int CLKS_PER_BIT = 32,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ack_n,
    input  logic       cts_n,
    output logic       tx,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic          TWO_STOP   = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_clkCnt;
    logic [2:0]    r_bitCnt;
    logic          r_stopCnt;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_ackN;
    logic          r_busy;
    logic          r_ctsMeta;
    logic          r_ctsSync;
    logic          w_ctsOk;
    logic          w_bitDone;

    assign w_ctsOk   = ~r_ctsSync;
    assign w_bitDone = (r_clkCnt == '0);

    assign tx         = r_tx;
    assign data_ack_n = r_ackN;
    assign busy       = r_busy;

    // Two-flop synchroniser for the asynchronous CTS line; resets to "not ready".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctsMeta <= 1'b1;
            r_ctsSync <= 1'b1;
        end else begin
            r_ctsMeta <= cts_n;
            r_ctsSync <= r_ctsMeta;
        end
    end

    // Frame sequencer. Every output is registered here, and the ack pulse lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_clkCnt  <= '0;
            r_bitCnt  <= '0;
            r_stopCnt <= 1'b0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_ackN    <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_ackN <= 1'b1;
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (data_valid && w_ctsOk) begin
                        r_shift  <= data;
                        r_clkCnt <= CNT_RELOAD;
                        r_state  <= START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_ackN   <= 1'b0;
                    end
                end
                START: begin
                    if (w_bitDone) begin
                        r_state  <= DATA;
                        r_clkCnt <= CNT_RELOAD;
                        r_bitCnt <= 3'd7;
                        r_tx     <= r_shift[0];
                    end else begin
                        r_clkCnt <= r_clkCnt - 1'b1;
                    end
                end
                DATA: begin
                    if (w_bitDone) begin
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_clkCnt <= CNT_RELOAD;
                        if (r_bitCnt == 3'd0) begin
                            r_state   <= STOP;
                            r_tx      <= 1'b1;
                            r_stopCnt <= TWO_STOP;
                        end else begin
                            r_bitCnt <= r_bitCnt - 1'b1;
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt - 1'b1;
                    end
                end
                STOP: begin
                    if (w_bitDone) begin
                        if (r_stopCnt) begin
                            r_stopCnt <= 1'b0;
                            r_clkCnt  <= CNT_RELOAD;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
// A loopback receiver decodes the tx line of the default instance. A second instance uses
// 8 clocks per bit and two stop bits, and its frame is checked sample by sample.
module tb_uart_tx;

    localparam int CPB  = 32;
    localparam int CPB2 = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cts_n;
    logic [7:0] data;
    logic       dataValid;
    logic       dataAckN;
    logic       tx;
    logic       busy;
    logic [7:0] data2;
    logic       dataValid2;
    logic       dataAckN2;
    logic       tx2;
    logic       busy2;

    int checks = 0;
    int errors = 0;

    logic [7:0] expQ[$];
    logic [7:0] rxQ[$];
    logic       rxStopQ[$];
    int         startQ[$];

    int         cycle = 0;
    bit         monActive = 1'b0;
    int         monStart = 0;
    int         monIdx = 0;
    logic       monPrev = 1'b1;
    logic [9:0] monBits = '0;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .data_valid (dataValid),
        .data_ack_n (dataAckN),
        .cts_n      (cts_n),
        .tx         (tx),
        .busy       (busy)
    );

    uart_tx #(.CLKS_PER_BIT(CPB2), .STOP_BITS(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data2),
        .data_valid (dataValid2),
        .data_ack_n (dataAckN2),
        .cts_n      (cts_n),
        .tx         (tx2),
        .busy       (busy2)
    );

    always #5 clk = ~clk;

    // Loopback receiver: finds each start edge, samples mid-bit, and queues the decoded byte and stop bit.
    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            monActive = 1'b0;
            monPrev   = 1'b1;
        end else begin
            if (!monActive && monPrev && !tx) begin
                monActive = 1'b1;
                monStart  = cycle;
                monIdx    = 0;
                startQ.push_back(cycle);
            end
            if (monActive && (cycle - monStart) == monIdx * CPB + CPB / 2) begin
                monBits[monIdx] = tx;
                monIdx++;
                if (monIdx == 10) begin
                    monActive = 1'b0;
                    rxQ.push_back(monBits[8:1]);
                    rxStopQ.push_back(monBits[9]);
                end
            end
            monPrev = tx;
        end
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitAck(output bit timedOut);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dataAckN !== 1'b0 && n < 10);
        timedOut = (dataAckN !== 1'b0);
    endtask

    task automatic waitIdle(output bit timedOut);
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        timedOut = (busy !== 1'b0);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        cts_n      = 1'b1;
        data       = 8'h00;
        dataValid  = 1'b0;
        data2      = 8'h00;
        dataValid2 = 1'b0;
        waitCycles(3);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx got %b want 1", tx); end
        checks++;
        if (dataAckN !== 1'b1) begin errors++; $display("[TB] FAIL reset_ack got %b want 1", dataAckN); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (tx2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_dut2 got tx %b busy %b want tx 1 busy 0", tx2, busy2);
        end
        rst_n = 1'b1;
        cts_n = 1'b0;
        waitCycles(4);
    endtask

    task automatic test_single();
        int   ackLow;
        int   busyCycles;
        bit   to;
        logic [7:0] got, want;
        logic stop;
        data      = 8'hA5;
        dataValid = 1'b1;
        @(negedge clk);
        checks++;
        if (dataAckN !== 1'b0 || tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept_a5 got ack %b tx %b busy %b want 0 0 1", dataAckN, tx, busy);
        end
        expQ.push_back(8'hA5);
        dataValid  = 1'b0;
        data       = 8'h00;
        ackLow     = (dataAckN === 1'b0) ? 1 : 0;
        busyCycles = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 400 && busy === 1'b1; i++) begin
            @(negedge clk);
            if (dataAckN === 1'b0) ackLow++;
            if (busy === 1'b1) busyCycles++;
        end
        checks++;
        if (ackLow != 1) begin errors++; $display("[TB] FAIL ack_width_a5 got %0d want 1", ackLow); end
        checks++;
        if (busyCycles != 10 * CPB) begin errors++; $display("[TB] FAIL busy_len_a5 got %0d want %0d", busyCycles, 10 * CPB); end
        waitIdle(to);
        want = expQ.pop_front();
        got  = (rxQ.size() > 0) ? rxQ.pop_front() : 8'hxx;
        stop = (rxStopQ.size() > 0) ? rxStopQ.pop_front() : 1'bx;
        checks++;
        if (got !== want || stop !== 1'b1) begin
            errors++; $display("[TB] FAIL frame_a5 got %h stop %b want %h stop 1", got, stop, want);
        end
    endtask

    task automatic test_cts_holdoff();
        int   badTx = 0;
        int   badAck = 0;
        int   waitN = 0;
        bit   to;
        logic [7:0] got, want;
        logic stop;
        cts_n = 1'b1;
        waitCycles(3);
        data      = 8'h55;
        dataValid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) badTx++;
            if (dataAckN !== 1'b1) badAck++;
        end
        checks++;
        if (badTx != 0) begin errors++; $display("[TB] FAIL holdoff_tx got %0d low samples want 0", badTx); end
        checks++;
        if (badAck != 0) begin errors++; $display("[TB] FAIL holdoff_ack got %0d ack samples want 0", badAck); end
        cts_n = 1'b0;
        do begin
            @(negedge clk);
            waitN++;
        end while (tx === 1'b1 && waitN < 10);
        checks++;
        if (waitN < 3 || waitN > 4) begin
            errors++; $display("[TB] FAIL cts_latency got %0d cycles want 3..4", waitN);
        end
        expQ.push_back(8'h55);
        dataValid = 1'b0;
        waitIdle(to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL idle_55 got busy %b want 0", busy); end
        want = expQ.pop_front();
        got  = (rxQ.size() > 0) ? rxQ.pop_front() : 8'hxx;
        stop = (rxStopQ.size() > 0) ? rxStopQ.pop_front() : 1'bx;
        checks++;
        if (got !== want || stop !== 1'b1) begin
            errors++; $display("[TB] FAIL frame_55 got %h stop %b want %h stop 1", got, stop, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int   sent = 0;
        int   guard = 0;
        bit   to;
        logic [7:0] got, want;
        logic stop;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h81;
        startQ.delete();
        data      = bytes[0];
        dataValid = 1'b1;
        while (sent < 3 && guard < 1500) begin
            @(negedge clk);
            guard++;
            if (dataAckN === 1'b0) begin
                expQ.push_back(bytes[sent]);
                sent++;
                if (sent < 3) data = bytes[sent];
                else dataValid = 1'b0;
            end
        end
        dataValid = 1'b0;
        checks++;
        if (sent != 3) begin errors++; $display("[TB] FAIL b2b_acks got %0d want 3", sent); end
        waitIdle(to);
        checks++;
        if (startQ.size() != 3) begin
            errors++; $display("[TB] FAIL b2b_starts got %0d want 3", startQ.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (startQ[i] - startQ[i-1] != 10 * CPB + 1) begin
                    errors++;
                    $display("[TB] FAIL b2b_gap%0d got %0d want %0d", i, startQ[i] - startQ[i-1], 10 * CPB + 1);
                end
            end
        end
        while (expQ.size() > 0) begin
            want = expQ.pop_front();
            got  = (rxQ.size() > 0) ? rxQ.pop_front() : 8'hxx;
            stop = (rxStopQ.size() > 0) ? rxStopQ.pop_front() : 1'bx;
            checks++;
            if (got !== want || stop !== 1'b1) begin
                errors++; $display("[TB] FAIL b2b_frame got %h stop %b want %h stop 1", got, stop, want);
            end
        end
    endtask

    task automatic test_cts_midframe();
        int   badAck = 0;
        bit   to;
        logic [7:0] got, want;
        logic stop;
        data      = 8'h3C;
        dataValid = 1'b1;
        @(negedge clk);
        checks++;
        if (dataAckN !== 1'b0) begin errors++; $display("[TB] FAIL accept_3c got %b want 0", dataAckN); end
        expQ.push_back(8'h3C);
        data = 8'h99;
        // N+145 sits in the middle of data bit 3 (N+129..N+160).
        waitCycles(144);
        cts_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (dataAckN === 1'b0) badAck++;
        end
        checks++;
        if (badAck != 0) begin errors++; $display("[TB] FAIL cts_hold_ack got %0d acks want 0", badAck); end
        want = expQ.pop_front();
        got  = (rxQ.size() > 0) ? rxQ.pop_front() : 8'hxx;
        stop = (rxStopQ.size() > 0) ? rxStopQ.pop_front() : 1'bx;
        checks++;
        if (got !== want || stop !== 1'b1) begin
            errors++; $display("[TB] FAIL frame_3c got %h stop %b want %h stop 1", got, stop, want);
        end
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL cts_hold_idle got tx %b busy %b want 1 0", tx, busy);
        end
        cts_n = 1'b0;
        waitAck(to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL resume_ack got %b want 0", dataAckN); end
        expQ.push_back(8'h99);
        dataValid = 1'b0;
        waitIdle(to);
        want = expQ.pop_front();
        got  = (rxQ.size() > 0) ? rxQ.pop_front() : 8'hxx;
        stop = (rxStopQ.size() > 0) ? rxStopQ.pop_front() : 1'bx;
        checks++;
        if (got !== want || stop !== 1'b1) begin
            errors++; $display("[TB] FAIL frame_99 got %h stop %b want %h stop 1", got, stop, want);
        end
    endtask

    task automatic test_reset_midframe();
        bit   to;
        logic [7:0] got, want;
        logic stop;
        data      = 8'h0F;
        dataValid = 1'b1;
        @(negedge clk);
        checks++;
        if (dataAckN !== 1'b0) begin errors++; $display("[TB] FAIL accept_0f got %b want 0", dataAckN); end
        dataValid = 1'b0;
        // N+209 is inside data bit 5 (N+193..N+224); bit 5 of 8'h0F is 0.
        waitCycles(208);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("[TB] FAIL bit5_0f got %b want 0", tx); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || dataAckN !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset got tx %b busy %b ack %b want 1 0 1", tx, busy, dataAckN);
        end
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(3);
        checks++;
        if (rxQ.size() != 0) begin errors++; $display("[TB] FAIL aborted_frame got %0d frames want 0", rxQ.size()); end
        data      = 8'h12;
        dataValid = 1'b1;
        waitAck(to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL accept_12 got %b want 0", dataAckN); end
        expQ.push_back(8'h12);
        dataValid = 1'b0;
        waitIdle(to);
        want = expQ.pop_front();
        got  = (rxQ.size() > 0) ? rxQ.pop_front() : 8'hxx;
        stop = (rxStopQ.size() > 0) ? rxStopQ.pop_front() : 1'bx;
        checks++;
        if (got !== want || stop !== 1'b1) begin
            errors++; $display("[TB] FAIL frame_12 got %h stop %b want %h stop 1", got, stop, want);
        end
    endtask

    task automatic test_two_stop();
        logic       txLog   [200];
        logic       busyLog [200];
        int         ackIdx[$];
        logic [7:0] c3 = 8'hC3;
        logic       expBit;
        int         bad = 0;
        int         busyLen = 0;
        data2      = 8'hC3;
        dataValid2 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            txLog[i]   = tx2;
            busyLog[i] = busy2;
            if (dataAckN2 === 1'b0) begin
                ackIdx.push_back(i);
                if (ackIdx.size() == 2) dataValid2 = 1'b0;
            end
        end
        dataValid2 = 1'b0;
        checks++;
        if (ackIdx.size() < 2 || ackIdx[0] != 0) begin
            errors++; $display("[TB] FAIL acks_c3 got %0d acks want first at sample 0 and a second", ackIdx.size());
        end
        // Start bit 0..7, data 8..71, two stop bits 72..87, IDLE decision at 88.
        for (int i = 0; i < 89; i++) begin
            if (i < CPB2) expBit = 1'b0;
            else if (i < 9 * CPB2) expBit = c3[(i - CPB2) / CPB2];
            else expBit = 1'b1;
            if (txLog[i] !== expBit) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL frame_c3 got %0d wrong samples want 0", bad); end
        while (busyLen < 200 && busyLog[busyLen] === 1'b1) busyLen++;
        checks++;
        if (busyLen != 11 * CPB2) begin errors++; $display("[TB] FAIL busy_len_c3 got %0d want %0d", busyLen, 11 * CPB2); end
        // The next start is at N+90, i.e. 89 samples after the first start bit.
        checks++;
        if (txLog[88] !== 1'b1 || txLog[89] !== 1'b0 || (ackIdx.size() >= 2 && ackIdx[1] != 89)) begin
            errors++;
            $display("[TB] FAIL next_start_c3 got tx88 %b tx89 %b want 1 0 at sample 89", txLog[88], txLog[89]);
        end
    endtask

    initial begin
        $display("[TB] uart_tx bench start");
        test_reset();
        test_single();
        test_cts_holdoff();
        test_back_to_back();
        test_cts_midframe();
        test_reset_midframe();
        test_two_stop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
